ift_stim_player: RTL

- Synthesizable, parametrised replay engine for IFT test stimulus.
- Holds DEPTH entries of {per-channel data, per-channel taint, hold delay}.
- Drives DUT data/taint inputs entry by entry, holding each entry for its programmed number of cycles, with optional looping.
- Sits between the bench (or an on-chip loader) and any IFT-instrumented DUT; replaces ad-hoc file-read-and-delay loops for multi-channel designs.

---
 rtl/ift_stim_pkg.sv | 31 +++
 rtl/ift_stim_mem.sv | 27 ++
 rtl/ift_stim_player.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ift_stim_pkg.sv
// Shared definitions for the IFT stimulus player: FSM state encodings and
// helpers describing how a stimulus entry is packed as {data, taint, delay}.
package ift_stim_pkg;

  // Player FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Total width of one packed stimulus entry
  function automatic int entry_width(int num_ch, int data_w, int taint_w, int delay_w);
    return num_ch * data_w + num_ch * taint_w + delay_w;
  endfunction

  // The delay field occupies the LSBs of an entry
  function automatic int delay_lsb();
    return 0;
  endfunction

  // The taint field sits directly above the delay field
  function automatic int taint_lsb(int delay_w);
    return delay_w;
  endfunction

  // The data field occupies the MSBs of an entry
  function automatic int data_lsb(int num_ch, int taint_w, int delay_w);
    return delay_w + num_ch * taint_w;
  endfunction

endpackage

// File: rtl/ift_stim_mem.sv
// Stimulus storage: simple dual-port RAM with one write port and one
// registered read port (1-cycle read latency). Contents are never reset.
module ift_stim_mem
  import ift_stim_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port plus registered read port, kept reset-free so it maps to block RAM
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/ift_stim_player.sv
// IFT stimulus replay engine. Plays cfg_len entries of {data, taint, delay}
// from a local RAM, holding each entry max(delay,1) cycles, optionally looping.
// The RAM read register acts as a one-entry prefetch buffer: the next entry is
// read at the same edge the current one is moved onto the outputs, so entries
// run back-to-back even with a hold of 1 and across the loop wrap.
// Optional build macro: IFT_STIM_TAINT_MASK_EN adds taint_mask_i, which zeroes
// taint_o per channel combinationally.
module ift_stim_player
  import ift_stim_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 1,
  parameter int TAINT_W = 32,
  parameter int DELAY_W = 32,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         wr_en_i,
  input  logic [ADDR_W-1:0]                            wr_addr_i,
  input  logic [NUM_CH*DATA_W+NUM_CH*TAINT_W+DELAY_W-1:0] wr_data_i,
  input  logic [ADDR_W:0]                              cfg_len_i,
  input  logic                                         cfg_loop_i,
  input  logic                                         start_i,
  input  logic                                         stop_i,
`ifdef IFT_STIM_TAINT_MASK_EN
  input  logic [NUM_CH-1:0]                            taint_mask_i,
`endif
  output logic [NUM_CH*DATA_W-1:0]                     data_o,
  output logic [NUM_CH*TAINT_W-1:0]                    taint_o,
  output logic                                         valid_o,
  output logic [ADDR_W-1:0]                            idx_o,
  output logic                                         busy_o,
  output logic                                         done_o
);

  localparam int ENTRY_W = entry_width(NUM_CH, DATA_W, TAINT_W, DELAY_W);
  localparam int DLY_LSB = delay_lsb();
  localparam int TNT_LSB = taint_lsb(DELAY_W);
  localparam int DAT_LSB = data_lsb(NUM_CH, TAINT_W, DELAY_W);
  localparam logic [ADDR_W:0]    DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [DELAY_W-1:0] ONE_L   = DELAY_W'(1);

  logic [1:0]                 state_q, state_d;
  logic [ADDR_W:0]            len_q, len_d;
  logic                       loop_q, loop_d;
  logic [ADDR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]          rd_idx_q, rd_idx_d;
  logic [DELAY_W-1:0]         cnt_q, cnt_d;
  logic [NUM_CH*DATA_W-1:0]   data_q, data_d;
  logic [NUM_CH*TAINT_W-1:0]  taint_q, taint_d;
  logic                       valid_q, valid_d;
  logic [ADDR_W-1:0]          idx_q, idx_d;
  logic                       done_q, done_d;

  logic [ENTRY_W-1:0]         rd_data;
  logic                       rd_en;
  logic [ADDR_W-1:0]          rd_addr;
  logic [ADDR_W-1:0]          rd_next;
  logic [ADDR_W:0]            last_idx;
  logic [ADDR_W:0]            len_clip;
  logic [DELAY_W-1:0]         rd_delay;
  logic [DELAY_W-1:0]         rd_hold;

  ift_stim_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk      (clk),
    .wr_en_i  (wr_en_i && (state_q == ST_IDLE)),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  // Prefetch address and its successor, wrapping at the last played entry
  always_comb begin
    last_idx = len_q - 1'b1;
    len_clip = (cfg_len_i > DEPTH_L) ? DEPTH_L : cfg_len_i;
    rd_addr  = (state_q == ST_FETCH) ? '0 : rd_ptr_q;
    rd_next  = ({1'b0, rd_addr} == last_idx) ? '0 : rd_addr + 1'b1;
    rd_delay = rd_data[DLY_LSB +: DELAY_W];
    rd_hold  = (rd_delay == '0) ? ONE_L : rd_delay;
  end

  // Playback FSM: next-state, prefetch and output-register logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    loop_d   = loop_q;
    rd_ptr_d = rd_ptr_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    taint_d  = taint_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_i && start_i) begin
          len_d  = len_clip;
          loop_d = cfg_loop_i;
          if (len_clip == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_next;
          rd_idx_d = rd_addr;
          state_d  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          data_d  = '0;
          taint_d = '0;
          valid_d = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (!valid_q || cnt_q == ONE_L) begin
          if (valid_q && ({1'b0, idx_q} == last_idx) && !loop_q) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            data_d  = '0;
            taint_d = '0;
            valid_d = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            data_d   = rd_data[DAT_LSB +: NUM_CH*DATA_W];
            taint_d  = rd_data[TNT_LSB +: NUM_CH*TAINT_W];
            valid_d  = 1'b1;
            idx_d    = rd_idx_q;
            cnt_d    = rd_hold;
            rd_en    = 1'b1;
            rd_ptr_d = rd_next;
            rd_idx_d = rd_addr;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      loop_q   <= 1'b0;
      rd_ptr_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      taint_q  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      rd_ptr_q <= rd_ptr_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      taint_q  <= taint_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;

`ifdef IFT_STIM_TAINT_MASK_EN
  // Per-channel taint gating, combinational so mask changes show immediately
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign taint_o[gi*TAINT_W +: TAINT_W] = taint_mask_i[gi] ? taint_q[gi*TAINT_W +: TAINT_W] : '0;
  end
`else
  assign taint_o = taint_q;
`endif

endmodule
